// File: rtl/hpi_pio_bank_if.sv
// hpi_pio_bank_if: Avalon-MM slave bus bundle between the NIOS fabric and the HPI PIO bank.
interface hpi_pio_bank_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hpi_pio_bank.sv
// hpi_pio_bank: Avalon-MM output PIO bank with per-channel one-shot strobes for the CY7C67200 HPI pins.
// Define HPI_PIO_SETCLR_EN to build the atomic SET/CLR register ops (op1/op2).

// One-shot strobe generator: strobe doubles as the busy flag.
module hpi_pio_strobe #(
  parameter int PULSE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic fire,
  output logic strobe,
  output logic overrun_evt
);
  localparam int CW = $clog2(PULSE_CYCLES + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // A fire that lands while the pulse is still high (final cycle included) is dropped and flagged.
  assign overrun_evt = fire & strobe;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          state  <= ACTIVE;
          cnt    <= CW'(PULSE_CYCLES);
          strobe <= 1'b1;
        end
        ACTIVE: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= IDLE;
            strobe <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

module hpi_pio_bank #(
  parameter int              WIDTH        = 8,
  parameter int              CHANNELS     = 4,
  parameter int              PULSE_CYCLES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  hpi_pio_bank_if.slave             bus,
  output logic [WIDTH*CHANNELS-1:0] out_port,
  output logic [CHANNELS-1:0]       strobe
);
  logic                           wr;
  logic [1:0]                     op, ch;
  logic                           ch_ok;
  logic [WIDTH-1:0]               wd;
  logic [CHANNELS-1:0][WIDTH-1:0] data;
  logic [CHANNELS-1:0]            fire, ov_set, ov_clr, overrun;
  logic [31:0]                    rd;
  logic                           unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign op        = bus.address[3:2];
  assign ch        = bus.address[1:0];
  assign ch_ok     = int'(ch) < CHANNELS;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= {CHANNELS{RESET_VALUE}};
    end else if (wr && ch_ok) begin
      case (op)
        2'd0: data[ch] <= wd;
`ifdef HPI_PIO_SETCLR_EN
        2'd1: data[ch] <= data[ch] | wd;
        2'd2: data[ch] <= data[ch] & ~wd;
`endif
        default: ;
      endcase
    end
  end

  assign out_port = data;

  assign fire   = (wr && bus.address == 4'd12) ? bus.writedata[CHANNELS-1:0]  : '0;
  assign ov_clr = (wr && bus.address == 4'd13) ? bus.writedata[4 +: CHANNELS] : '0;

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      hpi_pio_strobe #(.PULSE_CYCLES(PULSE_CYCLES)) u_stb (
        .clk         (clk),
        .reset       (reset),
        .fire        (fire[g]),
        .strobe      (strobe[g]),
        .overrun_evt (ov_set[g])
      );
    end
  endgenerate

  // A new overrun beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) overrun <= '0;
    else       overrun <= (overrun & ~ov_clr) | ov_set;
  end

  always_comb begin
    rd = '0;
    case (op)
      2'd0: if (ch_ok) rd[WIDTH-1:0] = data[ch];
`ifdef HPI_PIO_SETCLR_EN
      2'd1, 2'd2: if (ch_ok) rd[WIDTH-1:0] = data[ch];
`endif
      2'd3: begin
        if (ch == 2'd0) begin
          rd[CHANNELS-1:0] = strobe;
        end else if (ch == 2'd1) begin
          rd[CHANNELS-1:0]   = strobe;
          rd[4 +: CHANNELS]  = overrun;
        end
      end
      default: ;
    endcase
  end

  assign bus.readdata = rd;
endmodule
